// File: rtl/vpu_pkg.sv
// VPU shared types and constants: operand width plus destination-port line buffer types.
package vpu_pkg;

  localparam int OPERAND_WIDTH  = 32;
  localparam int DST_ELEMS      = 4;
  localparam int DST_ADDR_WIDTH = 8;
  localparam int DST_LEN_WIDTH  = $clog2(DST_ELEMS + 1);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } dst_buf_state_t;

  // One destination line being assembled; data element k sits at [k*OPERAND_WIDTH +: OPERAND_WIDTH].
  typedef struct packed {
    dst_buf_state_t                     state;
    logic [DST_ADDR_WIDTH-1:0]          addr;
    logic [DST_LEN_WIDTH-1:0]           len;
    logic [DST_LEN_WIDTH-1:0]           cnt;
    logic [DST_ELEMS*OPERAND_WIDTH-1:0] data;
  } dst_buf_t;

endpackage

// File: rtl/vpu_dst_port.sv
// Packs FP results into ping-pong destination lines; wr_valid_o rises 1 cycle after a line's last result.
// Write port may stall indefinitely (outputs held); upstream is throttled by credits via issue_ok_o.
module vpu_dst_port
  import vpu_pkg::*;
#(
  parameter int ELEMS      = DST_ELEMS,
  parameter int ADDR_WIDTH = DST_ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr_i,
  input  logic [$clog2(ELEMS+1)-1:0]     cmd_len_i,
  input  logic                           issue_i,
  output logic                           issue_ok_o,
  input  logic [OPERAND_WIDTH-1:0]       result_i,
  input  logic                           done_i,
  output logic                           wr_valid_o,
  input  logic                           wr_ready_i,
  output logic [ADDR_WIDTH-1:0]          wr_addr_o,
  output logic [ELEMS*OPERAND_WIDTH-1:0] wr_data_o,
  output logic [ELEMS-1:0]               wr_mask_o,
  output logic                           err_o
);

  localparam int LW = $clog2(ELEMS + 1);
  localparam int CW = $clog2(2 * ELEMS + 1);
  localparam int DW = ELEMS * OPERAND_WIDTH;

  dst_buf_t        buf_q [2];
  dst_buf_t        buf_d [2];
  logic            fill_ptr_q, fill_ptr_d;
  logic            drain_ptr_q, drain_ptr_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic            err_q, err_d;

  logic            any_fill;
  logic            fill_active;
  logic            cmd_hs;
  logic            len_bad;
  logic            wr_hs;
  logic [LW-1:0]   cnt_nxt;
  dst_buf_t        drain_buf;

  // Only buf[fill_ptr] can ever be in FILL; any_fill keeps the ready term explicit.
  assign any_fill    = (buf_q[0].state == FILL) || (buf_q[1].state == FILL);
  assign fill_active = (buf_q[fill_ptr_q].state == FILL);
  assign cmd_ready_o = !any_fill && (buf_q[fill_ptr_q].state == FREE);
  assign cmd_hs      = cmd_valid_i && cmd_ready_o;
  assign len_bad     = (cmd_len_i == '0) || (cmd_len_i > LW'(ELEMS));

  assign drain_buf   = buf_q[drain_ptr_q];
  assign wr_valid_o  = (drain_buf.state == FULL);
  assign wr_hs       = wr_valid_o && wr_ready_i;
  assign wr_addr_o   = wr_valid_o ? drain_buf.addr[ADDR_WIDTH-1:0] : '0;
  assign wr_data_o   = wr_valid_o ? drain_buf.data[DW-1:0] : '0;

  always_comb begin
    wr_mask_o = '0;
    for (int k = 0; k < ELEMS; k++) begin
      wr_mask_o[k] = wr_valid_o && (k < int'(drain_buf.len));
    end
  end

  assign issue_ok_o = (credit_q != '0);
  assign err_o      = err_q;

  always_comb begin
    buf_d       = buf_q;
    fill_ptr_d  = fill_ptr_q;
    drain_ptr_d = drain_ptr_q;
    credit_d    = credit_q;
    err_d       = err_q;
    cnt_nxt     = buf_q[fill_ptr_q].cnt + 1'b1;

    if (wr_hs) begin
      buf_d[drain_ptr_q].state = FREE;
      drain_ptr_d              = ~drain_ptr_q;
    end

    if (cmd_hs) begin
      if (len_bad) begin
        err_d = 1'b1;
      end else begin
        buf_d[fill_ptr_q]       = '0;
        buf_d[fill_ptr_q].state = FILL;
        buf_d[fill_ptr_q].addr  = cmd_addr_i;
        buf_d[fill_ptr_q].len   = cmd_len_i;
      end
    end

    if (done_i) begin
      if (fill_active) begin
        buf_d[fill_ptr_q].data[int'(buf_q[fill_ptr_q].cnt)*OPERAND_WIDTH +: OPERAND_WIDTH] = result_i;
        buf_d[fill_ptr_q].cnt = cnt_nxt;
        if (cnt_nxt == buf_q[fill_ptr_q].len) begin
          buf_d[fill_ptr_q].state = FULL;
          fill_ptr_d              = ~fill_ptr_q;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    // Returned credits and a same-cycle issue combine into one net update.
    if (wr_hs) begin
      credit_d = credit_d + CW'(drain_buf.len);
    end
    if (issue_i) begin
      if (credit_q != '0) begin
        credit_d = credit_d - 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      fill_ptr_q  <= 1'b0;
      drain_ptr_q <= 1'b0;
      credit_q    <= CW'(2 * ELEMS);
      err_q       <= 1'b0;
    end else begin
      buf_q[0]    <= buf_d[0];
      buf_q[1]    <= buf_d[1];
      fill_ptr_q  <= fill_ptr_d;
      drain_ptr_q <= drain_ptr_d;
      credit_q    <= credit_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_vpu_dst_port.sv
// Scoreboard bench for vpu_dst_port: expected lines queued when driven, compared on write handshake.
module tb_vpu_dst_port;
  import vpu_pkg::*;

  localparam int E  = 4;
  localparam int AW = 8;
  localparam int OW = OPERAND_WIDTH;

  logic                 clk;
  logic                 rst_n;
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [AW-1:0]        cmd_addr_i;
  logic [2:0]           cmd_len_i;
  logic                 issue_i;
  logic                 issue_ok_o;
  logic [OW-1:0]        result_i;
  logic                 done_i;
  logic                 wr_valid_o;
  logic                 wr_ready_i;
  logic [AW-1:0]        wr_addr_o;
  logic [E*OW-1:0]      wr_data_o;
  logic [E-1:0]         wr_mask_o;
  logic                 err_o;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [E*OW-1:0] data;
    logic [E-1:0]    mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  vpu_dst_port #(.ELEMS(E), .ADDR_WIDTH(AW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i (cmd_addr_i),
    .cmd_len_i  (cmd_len_i),
    .issue_i    (issue_i),
    .issue_ok_o (issue_ok_o),
    .result_i   (result_i),
    .done_i     (done_i),
    .wr_valid_o (wr_valid_o),
    .wr_ready_i (wr_ready_i),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .wr_mask_o  (wr_mask_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write-side monitor: compares handshakes with the scoreboard and checks stall stability.
  logic            stalled;
  logic [AW-1:0]   st_addr;
  logic [E*OW-1:0] st_data;
  logic [E-1:0]    st_mask;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", {127'd0, wr_valid_o}, 128'd1);
        check("stall_addr", {120'd0, wr_addr_o}, {120'd0, st_addr});
        check("stall_data", wr_data_o, st_data);
        check("stall_mask", {124'd0, wr_mask_o}, {124'd0, st_mask});
      end
      if (wr_valid_o && wr_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 128'd1, 128'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", {120'd0, wr_addr_o}, {120'd0, e.addr});
          check("wr_data", wr_data_o, e.data);
          check("wr_mask", {124'd0, wr_mask_o}, {124'd0, e.mask});
        end
      end
      stalled = wr_valid_o && !wr_ready_i;
      st_addr = wr_addr_o;
      st_data = wr_data_o;
      st_mask = wr_mask_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_len_i   = '0;
    issue_i     = 1'b0;
    result_i    = '0;
    done_i      = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, {127'd0, cmd_ready_o}, 128'd1);
    check({tag, "_issue_ok"},  {127'd0, issue_ok_o},  128'd1);
    check({tag, "_wr_valid"},  {127'd0, wr_valid_o},  128'd0);
    check({tag, "_wr_data"},   wr_data_o,             128'd0);
    check({tag, "_wr_mask"},   {124'd0, wr_mask_o},   128'd0);
    check({tag, "_wr_addr"},   {120'd0, wr_addr_o},   128'd0);
    check({tag, "_err"},       {127'd0, err_o},       128'd0);
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input int n);
    int guard;
    guard = 0;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_len_i   = 3'(n);
    while (!cmd_ready_o && guard < 50) begin
      tick();
      guard++;
    end
    if (!cmd_ready_o) check("cmd_timeout", 128'd0, 128'd1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      issue_i = 1'b1;
      tick();
    end
    issue_i = 1'b0;
  endtask

  // Full line: command, n issues, n results; the expected line is built here from the element list.
  task automatic send_line(input logic [AW-1:0] a, input int n, input logic [E*OW-1:0] vals);
    exp_t e;
    send_cmd(a, n);
    issue_n(n);
    e.addr = a;
    e.data = '0;
    e.mask = '0;
    for (int i = 0; i < n; i++) begin
      e.data[i*OW +: OW] = vals[i*OW +: OW];
      e.mask[i]          = 1'b1;
    end
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      done_i   = 1'b1;
      result_i = vals[i*OW +: OW];
      tick();
    end
    done_i   = 1'b0;
    result_i = '0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain_timeout", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    wr_ready_i = 1'b1;
    do_reset();
    check_reset_outputs("rst");
    check("rst_credit", 128'(u_dut.credit_q), 128'd8);

    // Single full line
    send_line(8'h10, 4, {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000});
    check("full_latency", {127'd0, wr_valid_o}, 128'd1);
    tick();
    check("full_credit", 128'(u_dut.credit_q), 128'd8);
    wait_drain(10);

    // Partial line
    send_line(8'h20, 2, {32'h0, 32'h0, 32'hAAAA0002, 32'hAAAA0001});
    check("part_latency", {127'd0, wr_valid_o}, 128'd1);
    check("part_mask", {124'd0, wr_mask_o}, 128'h3);
    check("part_upper", {64'd0, wr_data_o[127:64]}, 128'd0);
    wait_drain(10);
    tick();
    check("part_credit", 128'(u_dut.credit_q), 128'd8);

    // Ping-pong under back-pressure
    wr_ready_i = 1'b0;
    send_line(8'h01, 4, {32'h11110004, 32'h11110003, 32'h11110002, 32'h11110001});
    send_line(8'h02, 4, {32'h22220004, 32'h22220003, 32'h22220002, 32'h22220001});
    check("pp_cmd_ready", {127'd0, cmd_ready_o}, 128'd0);
    check("pp_issue_ok", {127'd0, issue_ok_o}, 128'd0);
    check("pp_credit", 128'(u_dut.credit_q), 128'd0);
    repeat (4) tick();
    check("pp_addr_hold", {120'd0, wr_addr_o}, 128'h01);
    wr_ready_i = 1'b1;
    tick();
    check("pp_cmd_ready_after", {127'd0, cmd_ready_o}, 128'd1);
    wait_drain(10);
    tick();
    check("pp_credit_back", 128'(u_dut.credit_q), 128'd8);

    // Issue and write handshake in the same cycle: 3 + 4 - 1
    wr_ready_i = 1'b0;
    send_line(8'h33, 4, {32'hC0000004, 32'hC0000003, 32'hC0000002, 32'hC0000001});
    issue_n(1);
    check("sim_credit_pre", 128'(u_dut.credit_q), 128'd3);
    wr_ready_i = 1'b1;
    issue_i    = 1'b1;
    tick();
    issue_i = 1'b0;
    check("sim_credit", 128'(u_dut.credit_q), 128'd6);
    wait_drain(10);
    check("sim_err", {127'd0, err_o}, 128'd0);

    // Protocol error: result without a line
    do_reset();
    done_i   = 1'b1;
    result_i = 32'hDEADBEEF;
    tick();
    done_i = 1'b0;
    check("orphan_err", {127'd0, err_o}, 128'd1);
    repeat (3) tick();
    check("orphan_no_wr", {127'd0, wr_valid_o}, 128'd0);

    // Protocol error: credit underflow
    do_reset();
    check("err_cleared", {127'd0, err_o}, 128'd0);
    issue_n(8);
    check("uf_err_before", {127'd0, err_o}, 128'd0);
    issue_n(1);
    check("uf_err", {127'd0, err_o}, 128'd1);
    check("uf_credit", 128'(u_dut.credit_q), 128'd0);
    check("uf_issue_ok", {127'd0, issue_ok_o}, 128'd0);

    // Bad length command is dropped
    do_reset();
    send_cmd(8'h44, 0);
    check("len0_err", {127'd0, err_o}, 128'd1);
    check("len0_ready", {127'd0, cmd_ready_o}, 128'd1);

    // Reset mid-fill
    do_reset();
    send_cmd(8'h55, 4);
    issue_n(4);
    done_i   = 1'b1;
    result_i = 32'h5555_0001;
    tick();
    result_i = 32'h5555_0002;
    tick();
    done_i = 1'b0;
    check("mid_cmd_ready", {127'd0, cmd_ready_o}, 128'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    #10;
    rst_n = 1'b1;
    tick();
    check("midrst_credit", 128'(u_dut.credit_q), 128'd8);
    send_line(8'h66, 3, {32'h0, 32'h66660003, 32'h66660002, 32'h66660001});
    check("post_rst_valid", {127'd0, wr_valid_o}, 128'd1);
    wait_drain(10);
    tick();
    check("post_rst_credit", 128'(u_dut.credit_q), 128'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vpu_dst_port.md
# vpu_dst_port

Destination port for the VPU FP execution units. It sits directly downstream of the FP max/compare stage and takes that stage's `result_o`/`done_o` element stream. It packs the elements into destination lines of `ELEMS` operands in a two-entry ping-pong line buffer, then writes each completed line back over a valid/ready write port. A credit counter tells the issuing side when it may start another element, because the FP units themselves cannot be back-pressured.

## Interface
Parameters:
- `ELEMS`, default 4: operands per destination line; must be at least 2.
- `ADDR_WIDTH`, default 8: width of the destination line address.

Ports:
- `clk`  in  1  clock. One clock domain; all logic is rising-edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `cmd_valid_i`  in  1  a destination-line command is offered.
- `cmd_ready_o`  out  1  the command is accepted this cycle.
- `cmd_addr_i`  in  ADDR_WIDTH  destination line address.
- `cmd_len_i`  in  $clog2(ELEMS+1)  number of elements in the line, 1..ELEMS.
- `issue_i`  in  1  the upstream pulses `start_i` to an FP unit this cycle.
- `issue_ok_o`  out  1  at least one credit is free.
- `result_i`  in  OPERAND_WIDTH  element result from the FP unit.
- `done_i`  in  1  `result_i` is valid.
- `wr_valid_o`  out  1  write request.
- `wr_ready_i`  in  1  the write is accepted.
- `wr_addr_o`  out  ADDR_WIDTH  write address.
- `wr_data_o`  out  ELEMS*OPERAND_WIDTH  write data; element k occupies bits [k*OW +: OW].
- `wr_mask_o`  out  ELEMS  bit k set when element k is valid.
- `err_o`  out  1  sticky protocol-error flag.

## Operation
- Each of the two line buffers has state FREE, FILL or FULL.
  - Buffer fields: addr, len, cnt, data.
  - A fill pointer and a drain pointer alternate between the buffers.
- FREE→FILL: on a command handshake (`cmd_valid_i && cmd_ready_o`) into buf[fill_ptr].
  - Stores addr and len; clears cnt and data.
- `cmd_ready_o` = (no buffer in FILL) && buf[fill_ptr]==FREE.
  - Registered-state function only; no path from `cmd_valid_i`.
- `done_i` while a buffer is in FILL:
  - data[cnt] ← `result_i`; cnt+1.
  - When cnt+1==len the buffer goes FILL→FULL and fill_ptr toggles.
- FULL→FREE: when `wr_valid_o && wr_ready_i` for buf[drain_ptr]; drain_ptr then toggles.
  - Drain order is strictly the fill order.
- Write outputs are driven from buf[drain_ptr] whenever it is FULL.
  - `wr_mask_o` = (1<<len)-1.
  - Elements at index len and above are 0.
  - Data, address and mask must hold stable while `wr_valid_o` is high and `wr_ready_i` is low.
- Credit counter:
  - Width $clog2(2*ELEMS+1); reset value 2*ELEMS.
  - Decrements by 1 on `issue_i`.
  - Increments by len on a write handshake; both in the same cycle give the net change.
  - `issue_ok_o` = credit != 0.
- `err_o` is set on any of the following and cleared only by reset:
  - `done_i` with no buffer in FILL: the result is dropped.
  - `issue_i` with credit 0: the counter stays at 0.
  - A command handshake with `cmd_len_i`==0 or greater than ELEMS: the command is dropped and the buffer stays FREE.

## Timing
- Reset values:
  - `cmd_ready_o`=1, `issue_ok_o`=1, `wr_valid_o`=0.
  - `wr_data_o`=0, `wr_mask_o`=0, `wr_addr_o`=0, `err_o`=0.
  - Both buffers FREE; both pointers 0.
- Reset asserted mid-operation discards all buffered data and outstanding credit immediately.
- Latency from the last `done_i` of a line to `wr_valid_o` is 1 cycle.
- A new command is accepted no earlier than the cycle after the FILL→FULL transition.
- `done_i` may arrive every cycle.
  - The upstream must send the line command before the first `issue_i` of that line.
  - That guarantees a FILL buffer exists when results arrive, given the fixed FP latency.
- Both buffers FULL gives `cmd_ready_o`=0 until the first write handshake.
  - `cmd_ready_o` rises in the cycle after that handshake.
- `done_i` and a command handshake are never in the same cycle for the same buffer: `cmd_ready_o` is 0 while any FILL exists.
- A write handshake and a FILL→FULL in the same cycle are legal; the pointers update independently.

## Structure
- VPU_PKG additions:
  - `DST_ELEMS` constant (default 4).
  - `dst_buf_state_t` enum {FREE, FILL, FULL}.
  - The per-line buffer struct.
- OPERAND_WIDTH is taken from VPU_PKG.
- No sub-module: the two buffers are an array of the struct inside the block.

## Test plan
- **Single full line.** Command addr=0x10, len=4; four `done_i` carrying 0x3F800000, 0x40000000, 0x40400000, 0x40800000; `wr_ready_i`=1.
  - → One cycle after the 4th result: `wr_valid_o`=1, `wr_addr_o`=0x10, `wr_mask_o`=4'b1111, data packed element 0 in the LSBs.
  - → Credit returns to 8.
- **Partial line.** len=2, results 0xAAAA0001 and 0xAAAA0002.
  - → `wr_mask_o`=4'b0011; upper 64 bits of data are 0.
- **Ping-pong under back-pressure.** `wr_ready_i`=0; fill two lines at 0x01 and 0x02.
  - → `cmd_ready_o`=0 and credit=0, so `issue_ok_o`=0.
  - → Raise `wr_ready_i`: 0x01 is written, then 0x02, in order, with data stable while stalled.
- **Protocol errors.** `done_i` with no command → `err_o`=1 and no write occurs. Separately, 9 `issue_i` pulses with no returns → `err_o`=1 and credit stays 0.
- **Simultaneous events.** An `issue_i` in the same cycle as a write handshake of len=4 with credit 3 → credit 6 the next cycle.
- **Reset mid-fill.** Assert `rst_n`=0 after 2 of 4 results → all outputs return to reset values; a new command completes normally afterwards.
